// File: rtl/seg7_scan_mux_if.sv
// Digit-in / pin-out bundle for the 4-digit 7-segment scan driver.
// master: the digit source and pin observer; slave: seg7_scan_mux.
`timescale 1ns/1ps

interface seg7_scan_mux_if;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic [3:0] dp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    modport master (
        output ones, tens, hundreds, thousands, dp_en,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  ones, tens, hundreds, thousands, dp_en,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit 7-segment driver with per-slot blanking guard and per-frame snapshot.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking on the shadow digits.
`timescale 1ns/1ps

module seg7_scan_mux #(
    parameter int unsigned REFRESH_DIV  = 25000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    seg7_scan_mux_if.slave bus
);

    localparam int unsigned   CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0]   cnt;
    logic [1:0]      slot;
    logic [3:0][3:0] shadow;
    logic [3:0]      shadow_dp;

    logic       slot_end;
    logic       frame_end;
    logic       lz_blank;
    logic       show;
    logic [3:0] an_on;
    logic [6:0] seg_on;
    logic       dp_on;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (slot == 2'd3);

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        lz_blank = 1'b0;
        unique case (slot)
            2'd3:    lz_blank = (shadow[3] == 4'd0);
            2'd2:    lz_blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0);
            2'd1:    lz_blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0) && (shadow[1] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        show   = (cnt >= CNT_BLANK) && !lz_blank;
        an_on  = 4'h0;
        seg_on = 7'h00;
        dp_on  = 1'b0;
        if (show) begin
            an_on  = 4'b0001 << slot;
            seg_on = decode(shadow[slot]);
            dp_on  = shadow_dp[slot];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            slot            <= 2'd0;
            shadow          <= '0;
            shadow_dp       <= 4'h0;
            bus.an          <= {4{ACTIVE_LOW}};
            bus.seg         <= {7{ACTIVE_LOW}};
            bus.dp          <= ACTIVE_LOW;
            bus.frame_start <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end) begin
                slot <= slot + 2'd1;
            end
            // Inputs are sampled only here so a counter carry can never tear a frame.
            if (frame_end) begin
                shadow    <= {bus.thousands, bus.hundreds, bus.tens, bus.ones};
                shadow_dp <= bus.dp_en;
            end
            bus.an          <= an_on  ^ {4{ACTIVE_LOW}};
            bus.seg         <= seg_on ^ {7{ACTIVE_LOW}};
            bus.dp          <= dp_on  ^ ACTIVE_LOW;
            bus.frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized + directed bench for seg7_scan_mux; one active-low and one active-high instance
// are checked every cycle against a position-based reference model.
`timescale 1ns/1ps

module tb_seg7_scan_mux;

    localparam int DIV = 8;
    localparam int BLK = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d [4];
    logic [3:0] dp_en_v;

    int total  = 0;
    int passed = 0;

    // Reference model state: position since reset release plus snapshot.
    int         p;
    logic [3:0] m_shadow [4];
    logic [3:0] m_dp;
    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    seg7_scan_mux_if bus_lo ();
    seg7_scan_mux_if bus_hi ();

    assign bus_lo.ones      = d[0];
    assign bus_lo.tens      = d[1];
    assign bus_lo.hundreds  = d[2];
    assign bus_lo.thousands = d[3];
    assign bus_lo.dp_en     = dp_en_v;
    assign bus_hi.ones      = d[0];
    assign bus_hi.tens      = d[1];
    assign bus_hi.hundreds  = d[2];
    assign bus_hi.thousands = d[3];
    assign bus_hi.dp_en     = dp_en_v;

    seg7_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lo)
    );

    seg7_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_hi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h (pos %0d)", tag, obs, exp, p);
    endtask

    function automatic bit lz_blanked(input int s);
`ifdef SEG7_LZ_BLANK_EN
        if (s == 0) return 1'b0;
        for (int j = s; j < 4; j++) begin
            if (m_shadow[j] != 4'd0) return 1'b0;
        end
        return 1'b1;
`else
        return (s < 0);
`endif
    endfunction

    task automatic model_reset();
        p = 0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'd0;
        m_dp = 4'h0;
    endtask

    task automatic step();
        int         c;
        int         s;
        bit         vis;
        bit         fs;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clk);
        c     = p % DIV;
        s     = (p / DIV) % 4;
        vis   = (c >= BLK) && !lz_blanked(s);
        e_an  = vis ? 4'(1 << s) : 4'h0;
        e_seg = vis ? tab[m_shadow[s]] : 7'h00;
        e_dp  = vis ? m_dp[s] : 1'b0;
        fs    = (c == DIV - 1) && (s == 3);
        if (fs) begin
            for (int i = 0; i < 4; i++) m_shadow[i] = d[i];
            m_dp = dp_en_v;
        end
        #1;
        chk("an_lo",  {3'b0, bus_lo.an},  {3'b0, ~e_an});
        chk("seg_lo", bus_lo.seg,         ~e_seg);
        chk("dp_lo",  {6'b0, bus_lo.dp},  {6'b0, ~e_dp});
        chk("fs_lo",  {6'b0, bus_lo.frame_start}, {6'b0, fs});
        chk("an_hi",  {3'b0, bus_hi.an},  {3'b0, e_an});
        chk("seg_hi", bus_hi.seg,         e_seg);
        chk("dp_hi",  {6'b0, bus_hi.dp},  {6'b0, e_dp});
        chk("fs_hi",  {6'b0, bus_hi.frame_start}, {6'b0, fs});
        p++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                              input logic [3:0] te, input logic [3:0] on,
                              input logic [3:0] dpe);
        d[3] = th; d[2] = hu; d[1] = te; d[0] = on; dp_en_v = dpe;
    endtask

    // Asserts reset away from a clock edge and checks the pins go inactive at once.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_an_lo",  {3'b0, bus_lo.an},  7'h0F);
        chk("rst_seg_lo", bus_lo.seg,         7'h7F);
        chk("rst_dp_lo",  {6'b0, bus_lo.dp},  7'h01);
        chk("rst_fs_lo",  {6'b0, bus_lo.frame_start}, 7'h00);
        chk("rst_an_hi",  {3'b0, bus_hi.an},  7'h00);
        chk("rst_seg_hi", bus_hi.seg,         7'h00);
        chk("rst_dp_hi",  {6'b0, bus_hi.dp},  7'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_digits();
        for (int i = 0; i < 4; i++) begin
            d[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        dp_en_v = 4'($urandom_range(0, 15));
    endtask

    initial begin
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame shows zeros, then 1234 after the snapshot.
        run(3 * 4 * DIV);
        run(DIV + 2);
        d[0] = 4'd9;
        run(2 * 4 * DIV);

        set_digits(4'd1, 4'd2, 4'hB, 4'd9, 4'b0010);
        run(2 * 4 * DIV);
        set_digits(4'd0, 4'd0, 4'd0, 4'd7, 4'h0);
        run(2 * 4 * DIV);
        set_digits(4'd8, 4'd8, 4'd8, 4'd8, 4'h0);
        run(2 * 4 * DIV + 5);

        mid_reset();
        run(2 * 4 * DIV);

        for (int f = 0; f < 40; f++) begin
            for (int c = 0; c < 4 * DIV; c++) begin
                step();
                if ($urandom_range(0, 11) == 0) rand_digits();
            end
            if (f == 20) begin
                run($urandom_range(1, 4 * DIV - 1));
                mid_reset();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
